coeff_bank_cdc: RTL and testbench

- Multi-channel coefficient selector that moves a selected coefficient bank from the i_clock_a domain into the i_clock_b domain.
- Uses a 4-phase req/ack handshake with multi-flop synchronizers. The data bus is held stable for the whole transfer, so no bus bits are synchronized.
- Successor to the single-channel, unsynchronized coefficient mux. Adds channel count, synchronizer depth, load/auto-select modes, one-deep pending request and a busy status.
- Sits between the control-register block (clock A) and the filter datapath (clock B).

---
 rtl/coeff_bank_cdc_pkg.sv | 34 +++
 rtl/sync_bit.sv | 29 ++
 rtl/coeff_bank_cdc.sv | 156 +++++++++++++++
 tb/tb_coeff_bank_cdc.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/coeff_bank_cdc_pkg.sv
// Shared types and helpers for the coefficient-bank clock-domain crossing.
//
// Contents:
//   a_state_e  : clock-A handshake FSM states
//   NB_DEF     : default bits per coefficient
//   NCH_DEF    : default coefficients per bank
//   NBUS       : packed bank width for the default configuration
//   get_chan() : extract channel k (width nb) from a packed bank
package coeff_bank_cdc_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StDrop = 2'd2
   } a_state_e;

   localparam int unsigned NB_DEF     = 8;
   localparam int unsigned NCH_DEF    = 4;
   localparam int unsigned NBUS       = NCH_DEF * NB_DEF;
   localparam int unsigned CHAN_W_MAX = 32;
   localparam int unsigned BUS_W_MAX  = 1024;

   // Channel k occupies bits [k*nb +: nb]; the bus is zero-extended by the caller.
   function automatic logic [CHAN_W_MAX-1:0] get_chan(input logic [BUS_W_MAX-1:0] bus,
                                                      input int unsigned k,
                                                      input int unsigned nb);
      logic [BUS_W_MAX-1:0] shifted;
      logic [BUS_W_MAX-1:0] mask;
      shifted = bus >> (k * nb);
      mask    = (BUS_W_MAX'(1) << nb) - BUS_W_MAX'(1);
      return CHAN_W_MAX'(shifted & mask);
   endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchronizer, reset value 0.
//
// Ports:
//   i_clock : destination clock
//   i_reset : synchronous active-high reset (tie low when synchronizing a reset)
//   i_d     : asynchronous input bit
//   o_q     : synchronized output, NSYNC destination edges of latency
module sync_bit #(
   parameter int unsigned NSYNC = 2
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic [NSYNC-1:0] sync_q;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[NSYNC-2:0], i_d};
      end
   end

   assign o_q = sync_q[NSYNC-1];

endmodule

// File: rtl/coeff_bank_cdc.sv
// Selects coefficient bank A or B in the clock-A domain and moves it into the
// clock-B domain with a 4-phase req/ack handshake. The captured bank (hold_q)
// only changes when a transfer launches from idle, so it is stable for the whole
// time req or the returning ack is high and needs no per-bit synchronization.
//
// Ports:
//   i_clock_a  : source clock
//   i_reset    : synchronous active-high reset, clock-A domain
//   i_clock_b  : destination clock
//   i_coeffs_a : bank A, channel k at [k*NB +: NB]
//   i_coeffs_b : bank B, same packing
//   i_sel      : 0 = bank A, 1 = bank B
//   i_load     : single-cycle load strobe (clock A)
//   o_busy     : clock A, a transfer is in flight
//   o_pending  : clock A, a load is queued behind the current transfer
//   o_coeffs   : clock B, registered output bank
//   o_update   : clock B, one-cycle pulse when o_coeffs is written
module coeff_bank_cdc
   import coeff_bank_cdc_pkg::*;
#(
   parameter int unsigned NB            = NB_DEF,
   parameter int unsigned NCH           = NCH_DEF,
   parameter int unsigned NSYNC         = 2,
   parameter bit          AUTO_SEL_LOAD = 1'b1
) (
   input  logic                i_clock_a,
   input  logic                i_reset,
   input  logic                i_clock_b,
   input  logic [NCH*NB-1:0]   i_coeffs_a,
   input  logic [NCH*NB-1:0]   i_coeffs_b,
   input  logic                i_sel,
   input  logic                i_load,
   output logic                o_busy,
   output logic                o_pending,
   output logic [NCH*NB-1:0]   o_coeffs,
   output logic                o_update
);

   localparam int unsigned BUS_W = NCH * NB;

   // ---------------- clock A side ----------------
   a_state_e          state_q, state_d;
   logic              req_q, req_d;
   logic              pend_q, pend_d;
   logic [BUS_W-1:0]  hold_q, hold_d;
   logic              sel_q;
   logic              ack_sync;
   logic              load_ev;

   // ---------------- clock B side ----------------
   logic              rst_b;
   logic              req_sync;
   logic              req_sync_q;
   logic              req_rise;

   assign load_ev = i_load | (AUTO_SEL_LOAD & (i_sel ^ sel_q));

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      pend_d  = pend_q;
      hold_d  = hold_q;
      unique case (state_q)
         StIdle: begin
            // A leftover ack after reset blocks the launch; the request waits as pending.
            if ((load_ev || pend_q) && !ack_sync) begin
               hold_d  = i_sel ? i_coeffs_b : i_coeffs_a;
               req_d   = 1'b1;
               pend_d  = 1'b0;
               state_d = StReq;
            end else if (load_ev) begin
               pend_d = 1'b1;
            end
         end
         StReq: begin
            if (load_ev) pend_d = 1'b1;
            if (ack_sync) begin
               req_d   = 1'b0;
               state_d = StDrop;
            end
         end
         StDrop: begin
            if (load_ev) pend_d = 1'b1;
            if (!ack_sync) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clock_a) begin
      if (i_reset) begin
         state_q <= StIdle;
         req_q   <= 1'b0;
         pend_q  <= 1'b0;
         hold_q  <= '0;
         sel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         pend_q  <= pend_d;
         hold_q  <= hold_d;
         sel_q   <= i_sel;
      end
   end

   assign o_busy    = (state_q != StIdle);
   assign o_pending = pend_q;

   // ack returns to A as the registered synchronized req seen by B.
   sync_bit #(
      .NSYNC (NSYNC)
   ) u_sync_ack (
      .i_clock (i_clock_a),
      .i_reset (i_reset),
      .i_d     (req_sync_q),
      .o_q     (ack_sync)
   );

   // B reset asserts and releases synchronously to clock B.
   sync_bit #(
      .NSYNC (NSYNC)
   ) u_sync_rst (
      .i_clock (i_clock_b),
      .i_reset (1'b0),
      .i_d     (i_reset),
      .o_q     (rst_b)
   );

   sync_bit #(
      .NSYNC (NSYNC)
   ) u_sync_req (
      .i_clock (i_clock_b),
      .i_reset (rst_b),
      .i_d     (req_q),
      .o_q     (req_sync)
   );

   // Only the rising edge transfers data; the falling edge just completes the handshake.
   assign req_rise = req_sync & ~req_sync_q;

   always_ff @(posedge i_clock_b) begin
      if (rst_b) begin
         req_sync_q <= 1'b0;
         o_update   <= 1'b0;
         o_coeffs   <= '0;
      end else begin
         req_sync_q <= req_sync;
         o_update   <= req_rise;
         if (req_rise) o_coeffs <= hold_q;
      end
   end

endmodule

// File: tb/tb_coeff_bank_cdc.sv
`timescale 1ns/1ps
module tb_coeff_bank_cdc;
   import coeff_bank_cdc_pkg::*;

   logic             clk_a = 1'b0;
   logic             clk_b = 1'b0;
   int               half_a = 5;
   int               half_b = 5;

   logic             i_reset;
   logic [NBUS-1:0]  i_coeffs_a;
   logic [NBUS-1:0]  i_coeffs_b;
   logic             i_sel;
   logic             i_load;
   logic             o_busy;
   logic             o_pending;
   logic [NBUS-1:0]  o_coeffs;
   logic             o_update;

   int               n_checks = 0;
   int               n_fail   = 0;
   int               n_upd    = 0;
   bit               allow_skip = 1'b0;
   logic [NBUS-1:0]  sb_q[$];

   // B edges land 2 ns after A falling edges while both periods are 10 ns.
   initial forever #(half_a) clk_a = ~clk_a;
   initial begin
      #12;
      clk_b = 1'b1;
      forever #(half_b) clk_b = ~clk_b;
   end

   coeff_bank_cdc #(
      .NB            (8),
      .NCH           (4),
      .NSYNC         (2),
      .AUTO_SEL_LOAD (1'b1)
   ) dut (
      .i_clock_a  (clk_a),
      .i_reset    (i_reset),
      .i_clock_b  (clk_b),
      .i_coeffs_a (i_coeffs_a),
      .i_coeffs_b (i_coeffs_b),
      .i_sel      (i_sel),
      .i_load     (i_load),
      .o_busy     (o_busy),
      .o_pending  (o_pending),
      .o_coeffs   (o_coeffs),
      .o_update   (o_update)
   );

   // Scoreboard consumer: every update must match the oldest expected bank. In the
   // random phase, entries superseded by a collapsed pending load may be skipped.
   logic [NBUS-1:0] mon_exp;
   logic            mon_have;
   always @(posedge clk_b) begin
      #1;
      if (o_update === 1'b1) begin
         n_upd++;
         if (allow_skip) begin
            while (sb_q.size() > 1 && sb_q[0] !== o_coeffs) void'(sb_q.pop_front());
         end
         mon_have = (sb_q.size() != 0);
         n_checks++;
         assert (mon_have === 1'b1) else begin
            n_fail++;
            $error("FAIL update_unexpected: observed update with %h, expected no update",
                   o_coeffs);
         end
         if (mon_have) begin
            mon_exp = sb_q.pop_front();
            n_checks++;
            assert (o_coeffs === mon_exp) else begin
               n_fail++;
               $error("FAIL update_value: observed %h, expected %h", o_coeffs, mon_exp);
            end
         end
      end
   end

   // Captured bank must not move while req or the returning ack is high.
   logic             prev_guard = 1'b0;
   logic [NBUS-1:0]  prev_hold = '0;
   logic             rst_edge;
   always @(posedge clk_a) begin
      rst_edge = i_reset;
      #1;
      if (prev_guard && !rst_edge) begin
         n_checks++;
         assert (dut.hold_q === prev_hold) else begin
            n_fail++;
            $error("FAIL hold_stable: observed %h, expected %h", dut.hold_q, prev_hold);
         end
      end
      prev_guard = dut.req_q | dut.ack_sync;
      prev_hold  = dut.hold_q;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: observed simulation still running, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [NBUS-1:0] got,
                        input logic [NBUS-1:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_idle(input int budget);
      bit done;
      done = 1'b0;
      repeat (2) @(negedge clk_a);
      for (int i = 0; i < budget; i++) begin
         if (!o_busy && !o_pending) begin
            done = 1'b1;
            break;
         end
         @(negedge clk_a);
      end
      check("idle_timeout", NBUS'(done), NBUS'(1));
      repeat (2) @(negedge clk_a);
   endtask

   int               u0;
   int               idx;
   logic [NBUS-1:0]  v0, new_a, new_b, last_exp;
   logic             ns;

   initial begin
      i_reset    = 1'b1;
      i_load     = 1'b0;
      i_sel      = 1'b0;
      i_coeffs_a = '0;
      i_coeffs_b = '0;
      repeat (8) @(negedge clk_a);
      check("rst_busy",    NBUS'(o_busy),    '0);
      check("rst_pending", NBUS'(o_pending), '0);
      check("rst_coeffs",  o_coeffs,         '0);
      check("rst_update",  NBUS'(o_update),  '0);
      i_reset = 1'b0;
      repeat (6) @(negedge clk_a);

      // Bank A select with an explicit load.
      u0 = n_upd;
      i_coeffs_a = 32'h44332211;
      i_load = 1'b1;
      sb_q.push_back(32'h44332211);
      @(negedge clk_a);
      i_load = 1'b0;
      check("busy_after_load", NBUS'(o_busy), NBUS'(1));
      wait_idle(100);
      check("bank_a_coeffs",  o_coeffs, 32'h44332211);
      check("bank_a_updates", NBUS'(n_upd - u0), NBUS'(1));
      for (int k = 0; k < 4; k++) begin
         check("bank_a_chan", NBUS'(get_chan(BUS_W_MAX'(o_coeffs), k, 8)), NBUS'((k + 1) * 17));
      end

      // Auto select: a bank-B change alone does nothing, the i_sel flip loads.
      @(negedge clk_a);
      i_coeffs_b = 32'hDDCCBBAA;
      @(negedge clk_a);
      check("no_load_idle", NBUS'(o_busy), '0);
      u0 = n_upd;
      i_sel = 1'b1;
      sb_q.push_back(32'hDDCCBBAA);
      wait_idle(100);
      check("auto_coeffs",  o_coeffs, 32'hDDCCBBAA);
      check("auto_updates", NBUS'(n_upd - u0), NBUS'(1));

      // Back to bank A (also an auto-select transfer).
      i_sel = 1'b0;
      sb_q.push_back(32'h44332211);
      wait_idle(100);

      // Pending collapse: three loads while the first transfer is in flight.
      u0 = n_upd;
      i_load = 1'b1;
      sb_q.push_back(32'h44332211);
      @(negedge clk_a);
      i_coeffs_a = 32'h01020304;
      sb_q.push_back(32'h01020304);
      @(negedge clk_a);
      @(negedge clk_a);
      @(negedge clk_a);
      i_load = 1'b0;
      check("pending_set", NBUS'(o_pending), NBUS'(1));
      wait_idle(200);
      check("collapse_updates", NBUS'(n_upd - u0), NBUS'(2));
      check("collapse_coeffs",  o_coeffs, 32'h01020304);

      // Hold stability: bank A churns every cycle while the transfer runs.
      u0 = n_upd;
      v0 = $urandom;
      i_coeffs_a = v0;
      i_load = 1'b1;
      sb_q.push_back(v0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_a);
         i_load = 1'b0;
         i_coeffs_a = $urandom;
         if (!o_busy) break;
      end
      wait_idle(100);
      check("hold_coeffs",  o_coeffs, v0);
      check("hold_updates", NBUS'(n_upd - u0), NBUS'(1));

      // Reset one A cycle after launch; that transfer must never surface.
      u0 = n_upd;
      i_coeffs_a = 32'h55667788;
      i_load = 1'b1;
      @(negedge clk_a);
      i_load = 1'b0;
      i_reset = 1'b1;
      repeat (2) @(negedge clk_a);
      check("rstmid_busy",    NBUS'(o_busy),    '0);
      check("rstmid_pending", NBUS'(o_pending), '0);
      repeat (4) @(negedge clk_a);
      check("rstmid_coeffs",  o_coeffs, '0);
      i_reset = 1'b0;
      repeat (6) @(negedge clk_a);
      check("rstmid_updates", NBUS'(n_upd - u0), '0);
      u0 = n_upd;
      i_coeffs_a = 32'h0A0B0C0D;
      i_load = 1'b1;
      sb_q.push_back(32'h0A0B0C0D);
      @(negedge clk_a);
      i_load = 1'b0;
      wait_idle(100);
      check("post_rst_coeffs",  o_coeffs, 32'h0A0B0C0D);
      check("post_rst_updates", NBUS'(n_upd - u0), NBUS'(1));

      // Random loads at three clock ratios; bank data only changes with a load event.
      allow_skip = 1'b1;
      idx = 0;
      last_exp = o_coeffs;
      for (int cfg = 0; cfg < 3; cfg++) begin
         case (cfg)
            0:       begin half_a = 5;  half_b = 15; end
            1:       begin half_a = 15; half_b = 5;  end
            default: begin half_a = 5;  half_b = 7;  end
         endcase
         repeat (4) @(negedge clk_a);
         if (cfg == 2) begin
            half_b = 5;
            repeat (4) @(negedge clk_a);
         end
         for (int n = 0; n < ((cfg == 2) ? 66 : 67); n++) begin
            repeat ($urandom_range(0, 10)) @(negedge clk_a);
            new_a = {idx[7:0], 24'($urandom)};
            new_b = {idx[7:0] ^ 8'h80, 24'($urandom)};
            ns    = 1'($urandom_range(0, 1));
            i_coeffs_a = new_a;
            i_coeffs_b = new_b;
            i_load = (ns != i_sel) ? 1'($urandom_range(0, 1)) : 1'b1;
            i_sel  = ns;
            last_exp = ns ? new_b : new_a;
            sb_q.push_back(last_exp);
            idx++;
            @(negedge clk_a);
            i_load = 1'b0;
         end
         wait_idle(600);
         check("rand_sb_empty", NBUS'(sb_q.size()), '0);
         check("rand_final",    o_coeffs, last_exp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
